// File: rtl/counter_gen_pkg.sv
// Shared definitions for counter_gen: mode encodings used by the RTL and the scoreboard driver/checker.
package counter_gen_pkg;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DN     = 2'b01,
        MODE_DNSTEP = 2'b10,
        MODE_LOAD   = 2'b11
    } mode_e;

endpackage

// File: rtl/counter_gen_next.sv
// Combinational next-state for counter_gen: next Q and boundary flag from (Q, mode, sat, D).
module counter_gen_next
    import counter_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic [WIDTH-1:0] q_i,
    input  mode_e            mode_i,
    input  logic             sat_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] next_q_o,
    output logic             bnd_o
);

    localparam logic [WIDTH:0] ONE_X  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    // Extra MSB carries the carry/borrow, which is the boundary flag itself.
    logic [WIDTH:0] inc, dec, dec_step;
    assign inc      = {1'b0, q_i} + ONE_X;
    assign dec      = {1'b0, q_i} - ONE_X;
    assign dec_step = {1'b0, q_i} - STEP_X;

    always_comb begin
        next_q_o = q_i;
        bnd_o    = 1'b0;
        unique case (mode_i)
            MODE_UP: begin
                bnd_o    = inc[WIDTH];
                next_q_o = (inc[WIDTH] && sat_i) ? q_i : inc[WIDTH-1:0];
            end
            MODE_DN: begin
                bnd_o    = dec[WIDTH];
                next_q_o = (dec[WIDTH] && sat_i) ? '0 : dec[WIDTH-1:0];
            end
            MODE_DNSTEP: begin
                bnd_o    = dec_step[WIDTH];
                next_q_o = (dec_step[WIDTH] && sat_i) ? '0 : dec_step[WIDTH-1:0];
            end
            MODE_LOAD: begin
                bnd_o    = 1'b0;
                next_q_o = d_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/counter_gen.sv
// Parametrised mode counter with wrap/saturate, boundary pulse and saturating rollover-event count.
module counter_gen
    import counter_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             sat,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load,
    output logic [CNT_W-1:0] wrap_cnt
);

    logic [WIDTH-1:0] q_q, q_d, next_q;
    logic             rco_q, rco_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             bnd;

    counter_gen_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .q_i      (q_q),
        .mode_i   (mode_e'(mode)),
        .sat_i    (sat),
        .d_i      (D),
        .next_q_o (next_q),
        .bnd_o    (bnd)
    );

    always_comb begin
        q_d    = q_q;
        rco_d  = 1'b0;
        load_d = 1'b0;
        if (enable) begin
            q_d    = next_q;
            rco_d  = bnd;
            load_d = (mode_e'(mode) == MODE_LOAD);
        end
        // Count tracks the rco being registered on this same edge.
        wcnt_d = (rco_d && (wcnt_q != '1)) ? wcnt_q + CNT_W'(1) : wcnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            rco_q  <= 1'b0;
            load_q <= 1'b0;
            wcnt_q <= '0;
        end else begin
            q_q    <= q_d;
            rco_q  <= rco_d;
            load_q <= load_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign Q        = q_q;
    assign rco      = rco_q;
    assign load     = load_q;
    assign wrap_cnt = wcnt_q;

endmodule

// File: tb/tb_counter_gen.sv
// Bench for counter_gen: directed scenarios plus random stimulus against an arithmetic reference model.
module tb_counter_gen;

    localparam int W    = 4;
    localparam int STEP = 3;
    localparam int MAX  = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset, enable, sat;
    logic [1:0]   mode;
    logic [W-1:0] D;

    logic [W-1:0] q8, q2;
    logic         rco8, rco2, load8, load2;
    logic [7:0]   wc8;
    logic [1:0]   wc2;

    counter_gen #(.WIDTH(W), .STEP(STEP), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D), .sat(sat),
        .Q(q8), .rco(rco8), .load(load8), .wrap_cnt(wc8)
    );

    counter_gen #(.WIDTH(W), .STEP(STEP), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D), .sat(sat),
        .Q(q2), .rco(rco2), .load(load2), .wrap_cnt(wc2)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    // Reference state
    int m_q, m_rco, m_load, m_wc8, m_wc2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_rco = 0; m_load = 0; m_wc8 = 0; m_wc2 = 0;
    endtask

    task automatic model_edge();
        m_rco  = 0;
        m_load = 0;
        if (enable) begin
            case (mode)
                2'b00: if (m_q == MAX) begin m_rco = 1; m_q = sat ? MAX : 0; end
                       else m_q = m_q + 1;
                2'b01: if (m_q == 0) begin m_rco = 1; m_q = sat ? 0 : MAX; end
                       else m_q = m_q - 1;
                2'b10: if (m_q < STEP) begin m_rco = 1; m_q = sat ? 0 : (m_q + MAX + 1 - STEP) % (MAX + 1); end
                       else m_q = m_q - STEP;
                default: begin m_q = int'(D); m_load = 1; end
            endcase
        end
        if (m_rco == 1) begin
            if (m_wc8 < 255) m_wc8++;
            if (m_wc2 < 3)   m_wc2++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Q"},     32'(q8),    32'(m_q));
        chk({tag, ".rco"},   32'(rco8),  32'(m_rco));
        chk({tag, ".load"},  32'(load8), 32'(m_load));
        chk({tag, ".wc8"},   32'(wc8),   32'(m_wc8));
        chk({tag, ".Q2"},    32'(q2),    32'(m_q));
        chk({tag, ".rco2"},  32'(rco2),  32'(m_rco));
        chk({tag, ".wc2"},   32'(wc2),   32'(m_wc2));
    endtask

    // Apply one set of inputs across one rising edge, then compare just after it.
    task automatic cyc(input string tag, input logic en, input logic [1:0] md,
                       input logic [W-1:0] d, input logic s);
        enable = en; mode = md; D = d; sat = s;
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
    endtask

    // Reset pulse placed between edges; outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all(tag);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; mode = 2'b00; D = '0; sat = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_all("por");
        @(negedge clk);
        reset = 1'b0;

        cyc("ld5", 1, 2'b11, 4'd5, 0);
        async_reset("arst");

        cyc("upw_ld14", 1, 2'b11, 4'd14, 0);
        cyc("upw_15",   1, 2'b00, 4'd0,  0);
        cyc("upw_0",    1, 2'b00, 4'd0,  0);
        chk("upw_wc_is1", 32'(wc8), 32'd1);

        cyc("dst_ld1", 1, 2'b11, 4'd1, 0);
        cyc("dst_14",  1, 2'b10, 4'd0, 0);
        cyc("dst_11",  1, 2'b10, 4'd0, 0);

        cyc("sat_ld15", 1, 2'b11, 4'd15, 1);
        for (int i = 0; i < 3; i++) cyc("sat_up", 1, 2'b00, 4'd0, 1);
        cyc("sat_ld2",  1, 2'b11, 4'd2, 1);
        cyc("sat_dst0", 1, 2'b10, 4'd0, 1);
        cyc("sat_dn0",  1, 2'b01, 4'd0, 1);

        cyc("hold_en0", 0, 2'b11, 4'd9, 0);
        cyc("hold_en1", 1, 2'b11, 4'd9, 0);

        async_reset("arst2");
        for (int i = 0; i < 5; i++) begin
            cyc("c2_ld15", 1, 2'b11, 4'd15, 0);
            cyc("c2_wrap", 1, 2'b00, 4'd0,  0);
        end
        chk("c2_wc_sat", 32'(wc2), 32'd3);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
            cyc("rnd", 1'($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
